// File: rtl/opnd_skew_feeder.sv
// Operand skew feeder: streams K rows from the operand SRAM into one edge of
// the systolic array. Lane i is delayed by i cycles relative to lane 0. The
// block also drives the array compute/flush controls and a completion pulse.
module opnd_skew_feeder #(
  parameter int unsigned NUM_LANES    = 32,
  parameter int unsigned OPND_BWIDTH  = 8,
  parameter int unsigned K_LEN_BWIDTH = 16
) (
  input  logic                             CLK,
  input  logic                             RSTn,
  input  logic                             STALL,
  input  logic                             START_in,
  input  logic [K_LEN_BWIDTH-1:0]          K_LEN_in,
  input  logic                             IN_VALID_in,
  output logic                             IN_READY_out,
  input  logic [NUM_LANES*OPND_BWIDTH-1:0] IN_DATA_in,
  output logic [NUM_LANES*OPND_BWIDTH-1:0] OPND_DATA_out,
  output logic [NUM_LANES-1:0]             OPND_IS_VALID_out,
  output logic                             IS_COMPUTING_out,
  output logic                             IS_FLUSHING_out,
  output logic                             BUSY_out,
  output logic                             DONE_out
);

  localparam int unsigned DRAIN_BWIDTH = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;
  localparam logic [DRAIN_BWIDTH-1:0] DRAIN_LAST = DRAIN_BWIDTH'(NUM_LANES - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  state_e                    state_q, state_d;
  logic [K_LEN_BWIDTH-1:0]   klen_q, klen_d;
  logic [K_LEN_BWIDTH-1:0]   row_q, row_d, row_inc;
  logic [DRAIN_BWIDTH-1:0]   drain_q, drain_d, drain_inc;
  logic                      done_q, done_d;
  logic                      is_comp_q, is_comp_d;
  logic                      is_flush_q, is_flush_d;
  logic                      accept_c;
  logic                      in_ready_c;

  // Next-state logic; a stall leaves every register at its current value.
  always_comb begin
    state_d    = state_q;
    klen_d     = klen_q;
    row_d      = row_q;
    drain_d    = drain_q;
    done_d     = done_q;
    is_comp_d  = is_comp_q;
    is_flush_d = is_flush_q;
    in_ready_c = 1'b0;
    accept_c   = 1'b0;
    row_inc    = row_q + K_LEN_BWIDTH'(1);
    drain_inc  = drain_q + DRAIN_BWIDTH'(1);

    if (!STALL) begin
      done_d     = 1'b0;
      is_comp_d  = (state_q != ST_IDLE);
      is_flush_d = (state_q == ST_DRAIN);
      unique case (state_q)
        ST_IDLE: begin
          if (START_in) begin
            if (K_LEN_in != '0) begin
              state_d = ST_LOAD;
              klen_d  = K_LEN_in;
              row_d   = '0;
            end else begin
              done_d = 1'b1;
            end
          end
        end
        ST_LOAD: begin
          in_ready_c = 1'b1;
          if (IN_VALID_in) begin
            accept_c = 1'b1;
            row_d    = row_inc;
            if (row_inc == klen_q) begin
              drain_d = '0;
              // A single-lane feeder has nothing left to drain after the last row.
              if (NUM_LANES == 1) begin
                state_d = ST_IDLE;
                done_d  = 1'b1;
              end else begin
                state_d = ST_DRAIN;
              end
            end
          end
        end
        ST_DRAIN: begin
          drain_d = drain_inc;
          if (drain_inc == DRAIN_LAST) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Control state register.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state_q    <= ST_IDLE;
      klen_q     <= '0;
      row_q      <= '0;
      drain_q    <= '0;
      done_q     <= 1'b0;
      is_comp_q  <= 1'b0;
      is_flush_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      klen_q     <= klen_d;
      row_q      <= row_d;
      drain_q    <= drain_d;
      done_q     <= done_d;
      is_comp_q  <= is_comp_d;
      is_flush_q <= is_flush_d;
    end
  end

  assign IN_READY_out     = in_ready_c;
  assign BUSY_out         = (state_q != ST_IDLE);
  assign DONE_out         = done_q;
  assign IS_COMPUTING_out = is_comp_q;
  assign IS_FLUSHING_out  = is_flush_q;

  // Per-lane skew chains: lane gi is gi+1 stages deep, bubbles carry zero data.
  for (genvar gi = 0; gi < NUM_LANES; gi++) begin : g_lane
    localparam int unsigned DEPTH      = gi + 1;
    localparam int unsigned DEPTH_BITS = DEPTH * OPND_BWIDTH;

    logic [DEPTH-1:0]                  vld_q, vld_d;
    logic [DEPTH-1:0][OPND_BWIDTH-1:0] dat_q, dat_d;
    logic [OPND_BWIDTH-1:0]            lane_in_c;

    assign lane_in_c = accept_c ? IN_DATA_in[gi*OPND_BWIDTH +: OPND_BWIDTH] : '0;
    assign vld_d     = DEPTH'({vld_q, accept_c});
    assign dat_d     = DEPTH_BITS'({dat_q, lane_in_c});

    // Shift one stage per unstalled cycle.
    always_ff @(posedge CLK or negedge RSTn) begin
      if (!RSTn) begin
        vld_q <= '0;
        dat_q <= '0;
      end else if (!STALL) begin
        vld_q <= vld_d;
        dat_q <= dat_d;
      end
    end

    assign OPND_IS_VALID_out[gi]                         = vld_q[DEPTH-1];
    assign OPND_DATA_out[gi*OPND_BWIDTH +: OPND_BWIDTH]  = dat_q[DEPTH-1];
  end

endmodule
